// File: rtl/tt_sel_ctrl_pkg.sv
// ============================================================================
// tt_sel_ctrl_pkg : shared widths, spine field offsets and FSM encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package tt_sel_ctrl_pkg;

  localparam int TT_N_IO  = 8;
  localparam int TT_N_O   = 8;
  localparam int TT_N_I   = 8;
  localparam int TT_SEL_W = 10;

  typedef logic [TT_SEL_W-1:0] sel_t;

  localparam logic [0:0] ST_SETTLE = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  // Inward spine: {0, ui, uio_in, sel, ena, 0}, LSB-relative offsets
  localparam int IW_ENA_BIT = 1;
  localparam int IW_SEL_LSB = 2;
  localparam int IW_UIO_LSB = IW_SEL_LSB + TT_SEL_W;

  function automatic int iw_ui_lsb(input int n_io);
    return IW_UIO_LSB + n_io;
  endfunction

  // Outward spine: {gh, uo, uio_out, uio_oe, gl}
  function automatic int ow_oe_lsb(input int n_io);
    return (n_io >= 0) ? 1 : 1;
  endfunction

  function automatic int ow_uio_lsb(input int n_io);
    return 1 + n_io;
  endfunction

  function automatic int ow_uo_lsb(input int n_io);
    return 1 + 2 * n_io;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tt_sel_sync.sv
// ============================================================================
// tt_sel_sync : 2-flop synchroniser, async active-low reset to 0
// Rev 1.0
// ============================================================================
`default_nettype none

module tt_sel_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

`default_nettype wire

// File: rtl/tt_sel_ctrl.sv
// ============================================================================
// tt_sel_ctrl : design-select address, guarded spine enable and pad/spine
//               word assembly for the row muxes
// Rev 1.0
// ============================================================================
`default_nettype none

module tt_sel_ctrl
  import tt_sel_ctrl_pkg::*;
#(
  parameter int N_IO    = TT_N_IO,
  parameter int N_O     = TT_N_O,
  parameter int N_I     = TT_N_I,
  parameter int GUARD   = 4,
  parameter int SEL_MAX = 1023,
  parameter int S_OW    = N_O + 2 * N_IO + 2,
  parameter int S_IW    = N_I + N_IO + 13
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ctrl_sel_inc,
  input  logic            ctrl_sel_clr,
  input  logic            ctrl_ena,
  input  logic [N_I-1:0]  pad_ui,
  input  logic [N_IO-1:0] pad_uio_in,
  output logic [N_O-1:0]  pad_uo,
  output logic [N_IO-1:0] pad_uio_out,
  output logic [N_IO-1:0] pad_uio_oe,
  output logic [S_IW-1:0] spine_iw,
  input  logic [S_OW-1:0] spine_ow,
  output logic [9:0]      sel
);

  localparam logic [3:0] GUARD_C    = 4'(GUARD);
  localparam sel_t       SEL_MAX_C  = sel_t'(SEL_MAX);
  localparam int         OW_OE_LSB  = ow_oe_lsb(N_IO);
  localparam int         OW_UIO_LSB = ow_uio_lsb(N_IO);
  localparam int         OW_UO_LSB  = ow_uo_lsb(N_IO);

  logic inc_s, clr_s, ena_s;

  tt_sel_sync u_sync_inc (.clk(clk), .rst_n(rst_n), .d(ctrl_sel_inc), .q(inc_s));
  tt_sel_sync u_sync_clr (.clk(clk), .rst_n(rst_n), .d(ctrl_sel_clr), .q(clr_s));
  tt_sel_sync u_sync_ena (.clk(clk), .rst_n(rst_n), .d(ctrl_ena),     .q(ena_s));

  logic            inc_prev_q, inc_prev_d;
  sel_t            sel_q, sel_d;
  logic [3:0]      gcnt_q, gcnt_d;
  logic [0:0]      state_q, state_d;
  logic [N_O-1:0]  uo_q, uo_d;
  logic [N_IO-1:0] uio_out_q, uio_out_d;
  logic [N_IO-1:0] uio_oe_q, uio_oe_d;

  logic inc_pulse;
  logic spine_ena;
  logic unused_ow_guards;

  assign inc_pulse = inc_s & ~inc_prev_q;
  assign spine_ena = (state_q == ST_ACTIVE);

  always_comb begin
    inc_prev_d = inc_s;
    sel_d      = sel_q;
    gcnt_d     = gcnt_q;

    // Every write of sel restarts the settle guard, even a write of 0 over 0.
    if (clr_s) begin
      sel_d  = '0;
      gcnt_d = GUARD_C;
    end else if (inc_pulse) begin
      sel_d  = (sel_q == SEL_MAX_C) ? '0 : sel_q + 1'b1;
      gcnt_d = GUARD_C;
    end else if (gcnt_q != 4'd0) begin
      gcnt_d = gcnt_q - 1'b1;
    end

    state_d = (ena_s && (gcnt_q == 4'd0) && !clr_s && !inc_pulse) ? ST_ACTIVE : ST_SETTLE;

    uo_d      = spine_ena ? spine_ow[OW_UO_LSB  +: N_O]  : '0;
    uio_out_d = spine_ena ? spine_ow[OW_UIO_LSB +: N_IO] : '0;
    uio_oe_d  = spine_ena ? spine_ow[OW_OE_LSB  +: N_IO] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inc_prev_q <= 1'b0;
      sel_q      <= '0;
      gcnt_q     <= GUARD_C;
      state_q    <= ST_SETTLE;
      uo_q       <= '0;
      uio_out_q  <= '0;
      uio_oe_q   <= '0;
    end else begin
      inc_prev_q <= inc_prev_d;
      sel_q      <= sel_d;
      gcnt_q     <= gcnt_d;
      state_q    <= state_d;
      uo_q       <= uo_d;
      uio_out_q  <= uio_out_d;
      uio_oe_q   <= uio_oe_d;
    end
  end

  assign unused_ow_guards = spine_ow[S_OW-1] ^ spine_ow[0];

  assign pad_uo      = uo_q;
  assign pad_uio_out = uio_out_q;
  assign pad_uio_oe  = uio_oe_q;
  assign sel         = sel_q;
  assign spine_iw    = {1'b0, pad_ui, pad_uio_in, sel_q, spine_ena, 1'b0};

endmodule

`default_nettype wire

// File: doc/tt_sel_ctrl.md
# tt_sel_ctrl

Spine controller that sits directly upstream of the row muxes and drives the vertical spine they decode. It holds the 10-bit design-select address, advanced by slow pad strobes. It gates the spine enable behind a settle guard so that no user design is enabled while the address is changing. It assembles the inward spine word from the pad inputs and extracts the outward spine word to the pad outputs, forcing those outputs to zero whenever no design is enabled.

## Interface
- `N_IO`, default `TT_N_IO`: bidirectional user pins.
- `N_O`, default `TT_N_O`: user outputs.
- `N_I`, default `TT_N_I`: user inputs.
- `GUARD`, default 4: clock cycles `spine_ena` stays low after any select change or reset; range 1..15.
- `SEL_MAX`, default 1023: last valid address; incrementing from it wraps to 0.
- `S_OW`/`S_IW`, auto: `N_O+2*N_IO+2` and `N_I+N_IO+13`.
- `clk`  in  1: block clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `ctrl_sel_inc`  in  1: asynchronous pad strobe; each rising edge advances the address by 1.
- `ctrl_sel_clr`  in  1: asynchronous pad level; while high, the address is held at 0 and the enable is held low.
- `ctrl_ena`  in  1: asynchronous pad level; requests enable of the selected design.
- `pad_ui`  in  `N_I`: user inputs; passed through combinationally.
- `pad_uio_in`  in  `N_IO`: bidirectional inputs; passed through combinationally.
- `pad_uo`  out  `N_O`: user outputs.
- `pad_uio_out`  out  `N_IO`: bidirectional outputs.
- `pad_uio_oe`  out  `N_IO`: bidirectional output enables.
- `spine_iw`  out  `S_IW`: `{1'b0, pad_ui, pad_uio_in, sel[9:0], spine_ena, 1'b0}`, MSB first.
- `spine_ow`  in  `S_OW`: `{gh, uo, uio_out, uio_oe, gl}`, MSB first; the guard bits are ignored.
- `sel`  out  10: current address; debug copy.

## Operation
- **Synchronisers.** `ctrl_sel_inc`, `ctrl_sel_clr` and `ctrl_ena` each pass through a 2-flop synchroniser. The synchronisers reset to 0.
- **Increment detection.** A rising edge of synchronised `inc` (current 1, previous 0) produces a 1-cycle `inc_pulse`.
- **Address register `sel`.**
  - If synchronised `clr`: `sel <= 0`.
  - Else if `inc_pulse`: `sel <= (sel == SEL_MAX) ? 0 : sel + 1`.
  - `clr` has priority over a simultaneous `inc_pulse`.
  - Unsigned 10-bit arithmetic.
- **Guard counter `gcnt` (4 bit).**
  - Loaded with `GUARD` whenever `sel` is written, including when the written value equals the old value, and whenever `clr` is high.
  - Otherwise decrements to 0 and saturates there.
- **Enable register `spine_ena`.**
  - Next value is synchronised `ena` AND `gcnt==0` AND NOT `clr` AND NOT `inc_pulse`.
  - It is therefore low in the same cycle the address changes.
- **FSM (2 states, derived from `gcnt`/`spine_ena`):**
  - SETTLE: `gcnt != 0`, or enable not yet asserted.
  - ACTIVE: `spine_ena == 1`.
  - ACTIVE→SETTLE on `inc_pulse`, on `clr`, or on synchronised `ena` falling.
- **Output path.**
  - `pad_uo`, `pad_uio_out`, `pad_uio_oe` are registered from `spine_ow` when `spine_ena` is high.
  - They are registered as 0 otherwise, so `pad_uio_oe` can never drive while no design is enabled.
- **Reset** (any time, including mid-settle):
  - `sel=0`, `gcnt=GUARD`, `spine_ena=0`, all pad outputs 0, synchronisers 0.
  - An `inc` edge pending in a synchroniser is discarded.
- **Strobe width.** Pad strobes must be high ≥2 `clk` and low ≥2 `clk`. Narrower pulses may be lost; this is not an error condition.

## Timing
- **Pad `inc` rise to `sel` update:** the synchroniser samples the edge at clock edge k; `inc_pulse` is asserted after edge k+1; `sel` updates at edge k+2.
- **Enable on `sel` update at edge m:** `spine_ena` is 0 from edge m. It returns to 1 at edge m+GUARD+1 if `ena` is held high.
- **Pad `clr`/`ena` level to effect:** 2 cycles for the synchroniser, plus 1 register stage.
- **`spine_ow` to pad outputs:** 1 cycle.
- **`spine_iw` user fields:** combinational from the pads. The `sel`/`ena` fields are registered.
- **Back-to-back `inc`:** every accepted `inc_pulse` restarts the guard; `spine_ena` stays 0 until `GUARD` quiet cycles have elapsed.

## Structure
- Widths `TT_N_IO`/`TT_N_O`/`TT_N_I` come from `tt_defs.vh`.
- Add `TT_SEL_W=10` and the spine field offsets to `tt_defs.vh`, shared with the row mux.
- One sub-module: `tt_sel_sync`, a 2-flop synchroniser with async active-low reset to 0, instantiated 3 times.

## Test plan
- **Reset:** release `rst_n`, hold `ctrl_ena=1` → `sel=0`; `spine_ena=0` for the first `GUARD` cycles after reset release, then rises; while it is low, all pad outputs are 0.
- **Increment:** 5 `inc` strobes (4 high / 4 low cycles), `ena=1` → `sel=5`; `spine_ena` drops each time `sel` updates and re-rises `GUARD+1` cycles after the last update.
- **Wrap:** with `SEL_MAX=3`, 4 strobes from 0 → `sel` goes 1, 2, 3, 0.
- **Clear priority:** `clr` and an `inc` edge landing on the same synchronised cycle with `sel=7` → `sel=0`, `spine_ena=0`.
- **Output gating:** `spine_ow` user field all-ones, toggle `ena` → pad outputs all-ones exactly 1 cycle after `spine_ena=1`, and 0 one cycle after it falls.
- **Reset mid-settle:** assert `rst_n=0` with `gcnt=2` and an `inc` edge in the synchroniser → after release `sel=0` (no increment) and the full `GUARD` delay is reapplied.
